ex_div_unit: RTL and testbench

//   Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in the EX stage.

---
 rtl/ex_div_unit.sv | 166 ++++++++++++++++
 tb/tb_ex_div_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports: clk, rst_n (async low), start, op[1:0], dividend, divisor, flush,
//        busy, stall_req, done, result.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow
//        skip CALC and finish one cycle after start.
module ex_div_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic             is_rem_q;
    logic             neg_q;
    logic             neg_r;
    logic             dz_q;

    logic             sgn_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             dz_in;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] calc_res;

    assign stall_req = ((state == S_IDLE) && start) || busy;

    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & dividend[WIDTH-1];
        b_neg  = sgn_op & divisor[WIDTH-1];
        abs_a  = a_neg ? -dividend : dividend;
        abs_b  = b_neg ? -divisor : divisor;
        dz_in  = (divisor == '0);
    end

`ifdef DIV_FASTPATH_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic             ovf_in;
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        ovf_in = sgn_op && (dividend == MIN_NEG) && (divisor == '1);
        if (dz_in)
            fast_res = op[1] ? dividend : '1;
        else
            fast_res = op[1] ? '0 : MIN_NEG;
    end
`endif

    // One restoring step; the final step feeds the sign fix-up so the
    // result is registered together with the done pulse.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dsr_q};
        ge      = ~diff[WIDTH];
        rem_nx  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx  = {dvd_q[WIDTH-2:0], ge};
        quo_fix = neg_q ? -quo_nx : quo_nx;
        rem_fix = neg_r ? -rem_nx : rem_nx;
        if (is_rem_q)
            calc_res = rem_fix;
        else if (dz_q)
            calc_res = '1;
        else
            calc_res = quo_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_q     <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_rem_q <= op[1];
                        dvd_q    <= abs_a;
                        dsr_q    <= abs_b;
                        rem_q    <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        dz_q     <= dz_in;
                        busy     <= 1'b1;
`ifdef DIV_FASTPATH_EN
                        if (dz_in || ovf_in) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= fast_res;
                        end else begin
                            state <= S_CALC;
                            count <= CNT_W'(WIDTH);
                        end
`else
                        state <= S_CALC;
                        count <= CNT_W'(WIDTH);
`endif
                    end
                end
                S_CALC: begin
                    rem_q <= rem_nx;
                    dvd_q <= quo_nx;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        result <= calc_res;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed vectors for ex_div_unit with hand-computed
// results and latencies (fast-path latency follows DIV_FASTPATH_EN).
module tb_ex_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_FASTPATH_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif

    ex_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit idle; returns #1 after
    // the edge that closes the done cycle.
    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int n;
        start = 1'b1;
        op = o;
        dividend = a;
        divisor = b;
        #1;
        chk({tag, "_stall_start"}, {31'd0, stall_req}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {30'd0, busy, stall_req}, 32'd0);
        chk({tag, "_res_hold"}, result, exp);
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        dividend = '0;
        divisor = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("div_20_m3", OP_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
        do_op("rem_20_m3", OP_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
        do_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, SP_LAT);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, SP_LAT);
        do_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SP_LAT);
        do_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, SP_LAT);
        do_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SP_LAT);
        do_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SP_LAT);
        do_op("remu_min_0", OP_REMU, 32'h8000_0000, 32'd0,
              32'h8000_0000, SP_LAT);

        // flush mid-CALC: abort silently, keep the previous result
        start = 1'b1;
        op = OP_DIVU;
        dividend = 32'd1000;
        divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_res", result, 32'h8000_0000);
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        chk("flush_no_done", n, 0);
        do_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);

        // flush beats start in IDLE
        start = 1'b1;
        flush = 1'b1;
        op = OP_DIVU;
        dividend = 32'd9;
        divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_start_res", result, 32'd333);

        // start while busy is ignored
        start = 1'b1;
        op = OP_DIVU;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b1;
        op = OP_REMU;
        dividend = 32'd1000;
        divisor = 32'd10;
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign_start_lat", n, 33);
        chk("ign_start_res", result, 32'd14);
        @(posedge clk);
        #1;
        chk("ign_start_idle", {31'd0, busy}, 32'd0);

        // async reset mid-CALC
        start = 1'b1;
        op = OP_DIVU;
        dividend = 32'd77;
        divisor = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_res", result, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("after_rst", OP_DIVU, 32'd77, 32'd5, 32'd15, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
